// File: rtl/pulse_seq_ctrl.sv
// Pulse sequencer: shifts a captured 16-bit pattern out MSB-first, rotating it
// rnd_q+1 times, with abort (stop) and a one-cycle completion strobe.
module pulse_seq_ctrl (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] pattern,
  input  logic [3:0]  rounds,
  output logic        pulse_out,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [3:0]  bit_idx,
  output logic [3:0]  round_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  // state_q is the hook for bound checkers and waveform debug.
  state_t      state_q, state_d;
  logic [15:0] sreg_q, sreg_d;
  logic [15:0] pat_q, pat_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [3:0]  round_cnt_q, round_cnt_d;
  logic        aborted_q, aborted_d;
  logic        busy_q, done_q;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    pat_d       = pat_q;
    rnd_d       = rnd_q;
    bit_idx_d   = bit_idx_q;
    round_cnt_d = round_cnt_q;
    aborted_d   = aborted_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d     = pattern;
          rnd_d     = rounds;
          aborted_d = 1'b0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (stop) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else begin
          sreg_d      = pat_q;
          bit_idx_d   = 4'd0;
          round_cnt_d = 4'd0;
          state_d     = RUN;
        end
      end
      RUN: begin
        // stop freezes everything, including on the final cycle.
        if (stop) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else begin
          sreg_d    = {sreg_q[14:0], sreg_q[15]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'hF) begin
            if (round_cnt_q == rnd_q) begin
              state_d = DONE;
            end else begin
              round_cnt_d = round_cnt_q + 4'd1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q     <= IDLE;
      sreg_q      <= 16'd0;
      pat_q       <= 16'd0;
      rnd_q       <= 4'd0;
      bit_idx_q   <= 4'd0;
      round_cnt_q <= 4'd0;
      aborted_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      pat_q       <= pat_d;
      rnd_q       <= rnd_d;
      bit_idx_q   <= bit_idx_d;
      round_cnt_q <= round_cnt_d;
      aborted_q   <= aborted_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

  assign pulse_out = (state_q == RUN) & sreg_q[15];
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign bit_idx   = bit_idx_q;
  assign round_cnt = round_cnt_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Bench for pulse_seq_ctrl: directed sequences plus randomized runs, compared
// cycle by cycle against an expected stream built from the pattern/rounds rules.
module tb_pulse_seq_ctrl;

  logic        CLK, CLR, start, stop;
  logic [15:0] pattern;
  logic [3:0]  rounds;
  logic        pulse_out, busy, done, aborted;
  logic [3:0]  bit_idx, round_cnt;

  int errors = 0;
  int checks = 0;

  // Per RUN cycle: {pulse_out, bit_idx, round_cnt}.
  logic [8:0] exp_q[$];

  pulse_seq_ctrl dut (
    .CLK(CLK), .CLR(CLR), .start(start), .stop(stop),
    .pattern(pattern), .rounds(rounds),
    .pulse_out(pulse_out), .busy(busy), .done(done), .aborted(aborted),
    .bit_idx(bit_idx), .round_cnt(round_cnt)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulse"}, pulse_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_aborted"}, aborted, 0);
    check({tag, "_bit_idx"}, bit_idx, 0);
    check({tag, "_round_cnt"}, round_cnt, 0);
  endtask

  // One full sequence starting from an IDLE cycle. stop_s: RUN cycle index
  // (0-based) during which stop is held, -1 for none. clr_at: RUN cycle index
  // at which CLR is pulsed, -1 for none. hold: keep start high throughout.
  task automatic run_seq(input logic [15:0] p, input logic [3:0] r, input int stop_s,
                         input bit with_stop, input bit hold, input int clr_at);
    int         n;
    int         k;
    bit         stopped;
    logic [8:0] e;
    n = 16 * (int'(r) + 1);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({p[15 - (i % 16)], 4'(i % 16), 4'(i / 16)});
    stopped = (stop_s >= 0) && (stop_s < n);
    if (stopped) while (exp_q.size() > stop_s + 1) void'(exp_q.pop_back());

    start = 1'b1; pattern = p; rounds = r; stop = with_stop;
    step();
    start = hold; stop = 1'b0;
    pattern = 16'($urandom); rounds = 4'($urandom);
    check("load_busy", busy, 1);
    check("load_done", done, 0);
    check("load_aborted", aborted, 0);
    check("load_pulse", pulse_out, 0);

    k = 0;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      if (k == clr_at) begin
        #2 CLR = 1'b1;
        #1 check_all_zero("clr_mid");
        step();
        CLR = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) begin
          step();
          check("post_clr_done", done, 0);
          check("post_clr_busy", busy, 0);
        end
        return;
      end
      check("run_pulse", pulse_out, e[8]);
      check("run_bit_idx", bit_idx, e[7:4]);
      check("run_round_cnt", round_cnt, e[3:0]);
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      stop    = (k == stop_s);
      start   = hold ? 1'b1 : 1'($urandom_range(0, 1));
      pattern = 16'($urandom);
      rounds  = 4'($urandom);
      k++;
    end

    step();
    check("done_strobe", done, 1);
    check("done_busy", busy, 1);
    check("done_pulse", pulse_out, 0);
    check("done_aborted", aborted, stopped);
    check("done_bit_idx", bit_idx, stopped ? 4'(stop_s % 16) : 4'd0);
    check("done_round_cnt", round_cnt, stopped ? 4'(stop_s / 16) : r);
    stop  = 1'($urandom_range(0, 1));
    start = hold ? 1'b1 : 1'($urandom_range(0, 1));

    step();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_pulse", pulse_out, 0);
    check("idle_aborted_held", aborted, stopped);
    start = hold; stop = 1'b0;
  endtask

  initial begin
    int         s;
    logic [3:0] r;
    CLR = 1'b1; start = 1'b0; stop = 1'b0; pattern = 16'd0; rounds = 4'd0;
    repeat (2) @(posedge CLK);
    #1 check_all_zero("reset");
    CLR = 1'b0;

    // basic, multi-round, abort at bit 5
    run_seq(16'h8001, 4'd0, -1, 1'b0, 1'b0, -1);
    run_seq(16'hA5A5, 4'd2, -1, 1'b0, 1'b0, -1);
    run_seq(16'hFFFF, 4'd15, 5, 1'b0, 1'b0, -1);

    // stop on the last RUN cycle still reports an abort
    run_seq(16'($urandom), 4'd1, 31, 1'b0, 1'b0, -1);

    // start and stop together in IDLE starts a sequence
    run_seq(16'($urandom), 4'd0, -1, 1'b1, 1'b0, -1);

    // start held: second sequence accepted right after the single IDLE cycle
    run_seq(16'($urandom), 4'd1, -1, 1'b0, 1'b1, -1);
    run_seq(16'($urandom), 4'd0, -1, 1'b0, 1'b0, -1);

    // no restart without start; stop in IDLE ignored
    repeat (5) begin
      stop = 1'($urandom_range(0, 1));
      step();
      check("idle_stays_busy", busy, 0);
      check("idle_stays_done", done, 0);
    end
    stop = 1'b0;

    // reset mid-run, then a full sequence right after
    run_seq(16'($urandom), 4'd3, -1, 1'b0, 1'b0, 20);
    run_seq(16'($urandom), 4'd3, -1, 1'b0, 1'b0, -1);

    // randomized sequences
    repeat (8) begin
      r = 4'($urandom_range(0, 2));
      s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 16 * (int'(r) + 1) - 1)) : -1;
      run_seq(16'($urandom), r, s, 1'($urandom_range(0, 1)), 1'b0, -1);
      repeat ($urandom_range(0, 2)) begin
        step();
        check("gap_busy", busy, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
